// File: rtl/add_accumulator_pkg.sv
// Shared width and FSM encoding for the frame accumulator and its ripple-carry adder.
package add_accumulator_pkg;

    localparam int ACC_N = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_accumulator_fa.sv
// N-bit ripple-carry adder (generate_fa): one full-adder cell per bit, carry chained LSB to MSB.
module generate_fa
    import add_accumulator_pkg::*;
#(
    parameter int N = ACC_N
) (
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         c_in,
    output logic [N-1:0] sum_out,
    output logic         carry_out
);

    logic [N:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum_out[i] = a_in[i] ^ b_in[i] ^ w_c[i];
        assign w_c[i+1]   = (a_in[i] & b_in[i]) | (w_c[i] & (a_in[i] ^ b_in[i]));
    end

    assign carry_out = w_c[N];

endmodule

// File: rtl/add_accumulator.sv
// Frame accumulator: sums len_in samples over valid/ready and hands back sum plus sticky overflow.
module add_accumulator
    import add_accumulator_pkg::*;
#(
    parameter int N     = ACC_N,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [CNT_W-1:0] len_in,
    input  logic             data_valid_in,
    input  logic [N-1:0]     data_in,
    output logic             data_ready_out,
    output logic             result_valid_out,
    input  logic             result_ready_in,
    output logic [N-1:0]     sum_out,
    output logic             carry_out,
    output logic             busy_out
);

    state_t           r_state, w_next;
    logic [N-1:0]     r_acc, r_sum, w_add_sum;
    logic             r_ovf, r_carry, w_add_c;
    logic [CNT_W-1:0] r_rem;
    logic             w_start, w_xfer, w_last;

    assign w_start = (r_state == S_IDLE) && start_in;
    assign w_xfer  = (r_state == S_ACC) && data_valid_in;
    assign w_last  = w_xfer && (r_rem == CNT_W'(1));

    generate_fa #(.N(N)) u_fa (
        .a_in     (r_acc),
        .b_in     (data_in),
        .c_in     (1'b0),
        .sum_out  (w_add_sum),
        .carry_out(w_add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_in) w_next = (len_in == '0) ? S_DONE : S_ACC;
            S_ACC:  if (w_last) w_next = S_DONE;
            S_DONE: if (result_ready_in) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output registers load only on entry to DONE, so they hold steady through IDLE/ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_rem   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_rem <= len_in;
            if (len_in == '0) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
            end
        end else if (w_xfer) begin
            r_acc <= w_add_sum;
            r_ovf <= r_ovf | w_add_c;
            r_rem <= r_rem - CNT_W'(1);
            if (w_last) begin
                r_sum   <= w_add_sum;
                r_carry <= r_ovf | w_add_c;
            end
        end
    end

    assign data_ready_out   = (r_state == S_ACC);
    assign result_valid_out = (r_state == S_DONE);
    assign busy_out         = (r_state != S_IDLE);
    assign sum_out          = r_sum;
    assign carry_out        = r_carry;

endmodule

// File: tb/tb_add_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops on result handoff.
module tb_add_accumulator;

    localparam int N = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         carry;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_in = 1'b0;
    logic [CNT_W-1:0] len_in = '0;
    logic             data_valid_in = 1'b0;
    logic [N-1:0]     data_in = '0;
    logic             data_ready_out;
    logic             result_valid_out;
    logic             result_ready_in = 1'b1;
    logic [N-1:0]     sum_out;
    logic             carry_out;
    logic             busy_out;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    add_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_in        (start_in),
        .len_in          (len_in),
        .data_valid_in   (data_valid_in),
        .data_in         (data_in),
        .data_ready_out  (data_ready_out),
        .result_valid_out(result_valid_out),
        .result_ready_in (result_ready_in),
        .sum_out         (sum_out),
        .carry_out       (carry_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result handoff is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid_out && result_ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum_out), 32'(e.sum));
                check("sb_carry", 32'(carry_out), 32'(e.carry));
            end
        end
    end

    task automatic start_frame(input int len, input logic [N-1:0] esum, input logic ecarry);
        res_t e;
        e.sum = esum;
        e.carry = ecarry;
        exp_q.push_back(e);
        start_in = 1'b1;
        len_in = CNT_W'(len);
        @(posedge clk); #1;
        start_in = 1'b0;
        check("start_busy", 32'(busy_out), 32'd1);
        if (len != 0) check("start_ready", 32'(data_ready_out), 32'd1);
        else          check("len0_valid", 32'(result_valid_out), 32'd1);
    endtask

    task automatic send(input logic [N-1:0] d, input logic v);
        data_valid_in = v;
        data_in = d;
        @(posedge clk); #1;
        data_valid_in = 1'b0;
        data_in = 8'hEE;
    endtask

    // Bounded wait for the FSM to hand off the result and settle back in IDLE.
    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_out || result_valid_out) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(busy_out), 32'd0);
    endtask

    initial begin
        logic [N-1:0] held_sum;
        logic         held_carry;

        #2;
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_valid", 32'(result_valid_out), 32'd0);
        check("rst_ready", 32'(data_ready_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-frame: 2 of 4 samples, then async reset between edges
        start_in = 1'b1; len_in = 4'd4;
        @(posedge clk); #1;
        start_in = 1'b0;
        send(8'd1, 1'b1);
        send(8'd2, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_ready", 32'(data_ready_out), 32'd0);
        check("midrst_valid", 32'(result_valid_out), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle", 32'(busy_out), 32'd0);

        start_frame(2, 8'd7, 1'b0);
        send(8'd3, 1'b1);
        send(8'd4, 1'b1);
        check("f0_latency", 32'(result_valid_out), 32'd1);
        wait_idle("f0_idle");

        // Basic frame, valid held high
        start_frame(3, 8'd60, 1'b0);
        send(8'd10, 1'b1);
        send(8'd20, 1'b1);
        check("f1_not_early", 32'(result_valid_out), 32'd0);
        send(8'd30, 1'b1);
        check("f1_latency", 32'(result_valid_out), 32'd1);
        wait_idle("f1_idle");

        // Overflow: 200+100 = 300 -> 44, carry
        start_frame(2, 8'd44, 1'b1);
        send(8'd200, 1'b1);
        send(8'd100, 1'b1);
        wait_idle("f2_idle");

        // Sticky: 255+1 wraps to 0, +5 -> 5, carry stays
        start_frame(3, 8'd5, 1'b1);
        send(8'd255, 1'b1);
        send(8'd1, 1'b1);
        send(8'd5, 1'b1);
        wait_idle("f3_idle");

        // Valid gaps 1,0,0,1: only 7 and 9 are taken
        start_frame(2, 8'd16, 1'b0);
        send(8'd7, 1'b1);
        send(8'd99, 1'b0);
        send(8'd99, 1'b0);
        check("gap_still_acc", 32'(data_ready_out), 32'd1);
        send(8'd9, 1'b1);
        check("gap_latency", 32'(result_valid_out), 32'd1);
        wait_idle("f4_idle");

        // Empty frame
        start_frame(0, 8'd0, 1'b0);
        wait_idle("f5_idle");

        // Result back-pressure with start/data pushed at the block
        result_ready_in = 1'b0;
        start_frame(2, 8'd4, 1'b1);
        send(8'd250, 1'b1);
        send(8'd10, 1'b1);
        held_sum = 8'd4;
        held_carry = 1'b1;
        start_in = 1'b1; len_in = 4'd3;
        data_valid_in = 1'b1; data_in = 8'd77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(result_valid_out), 32'd1);
            check("bp_sum", 32'(sum_out), 32'(held_sum));
            check("bp_carry", 32'(carry_out), 32'(held_carry));
            check("bp_ready", 32'(data_ready_out), 32'd0);
        end
        start_in = 1'b0;
        data_valid_in = 1'b0;
        result_ready_in = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", 32'(busy_out), 32'd0);
        check("bp_idle_valid", 32'(result_valid_out), 32'd0);
        check("bp_hold_sum", 32'(sum_out), 32'(held_sum));

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_accumulator.md
# add_accumulator

Sequential accumulator that collects a frame of N-bit samples over a valid/ready handshake and returns their running sum with a sticky overflow flag. It sits directly upstream of and around the team's N-bit ripple-carry adder (`generate_fa`): it feeds the adder its operands each cycle and registers the sum and carry it produces. It turns the purely combinational adder into a frame-based, back-pressured datapath stage.

## Interface
- `N`, default 8: sample and accumulator width; must equal the adder's `` `N ``.
- `CNT_W`, default 4: width of the frame-length field; maximum frame is 2^CNT_W − 1 samples.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_in`  in  1  frame start request; sampled only in IDLE.
- `len_in`  in  CNT_W  number of samples in the frame; captured with `start_in`.
- `data_valid_in`  in  1  sample valid.
- `data_in`  in  N  sample value, unsigned.
- `data_ready_out`  out  1  block accepts a sample this cycle.
- `result_valid_out`  out  1  `sum_out`/`carry_out` are valid.
- `result_ready_in`  in  1  consumer takes the result.
- `sum_out`  out  N  accumulated sum, modulo 2^N.
- `carry_out`  out  1  sticky overflow: set if any addition in the frame carried out.
- `busy_out`  out  1  high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, ACC and DONE.
- **IDLE:** `data_ready_out`=0.
  - `start_in`=1 with `len_in`≠0: clear the accumulator and overflow flag, load `remaining`=`len_in`, go to ACC.
  - `start_in`=1 with `len_in`=0: clear the accumulator and flag, go directly to DONE (empty frame yields sum 0, carry 0).
- **ACC:** `data_ready_out`=1.
  - A transfer occurs when `data_valid_in`&`data_ready_out`.
  - On each transfer: the adder computes acc + `data_in` with c_in=0; acc ← sum; ovf ← ovf | carry; `remaining` decrements.
  - A transfer with `remaining`=1 is the last one and moves the FSM to DONE.
  - With `data_valid_in` low, nothing changes.
- **DONE:**
  - `result_valid_out`=1; `sum_out` shows acc and `carry_out` shows ovf.
  - Both outputs are held stable until `result_ready_in`=1, then the FSM returns to IDLE.
  - `data_ready_out`=0.
- `start_in` outside IDLE is ignored; there is no queuing.
- `sum_out` and `carry_out` are registered. They hold their last values in IDLE and ACC, but are qualified only by `result_valid_out`.
- Arithmetic: unsigned, wraps modulo 2^N. Overflow is only flagged, never saturated.

## Timing
- **Reset** (asynchronous, `rst_n`=0): state=IDLE; `data_ready_out`, `result_valid_out`, `busy_out`, `carry_out`=0; `sum_out`=0; acc, ovf and `remaining` are 0.
- **Reset mid-frame:** the frame is aborted, all partial data is lost, and no result is produced.
- **Start:** `start_in` in IDLE at edge k gives `busy_out`=1 and `data_ready_out`=1 from cycle k+1.
- **Throughput:** one sample per cycle while `data_valid_in` is held high.
- **Result latency:** `result_valid_out` rises the cycle after the last accepted sample. A full frame of L samples takes L+1 cycles from start to result, and L=0 takes 1 cycle.
- **Result handshake:** if `result_ready_in` is already high when `result_valid_out` rises, the result is consumed in that one cycle and the FSM is back in IDLE the following cycle.
- **Back-to-back frames:** a new `start_in` is accepted at the earliest in the first IDLE cycle after result handoff. The minimum gap is therefore one idle cycle.
- **Combinational paths:** none from inputs to outputs; all outputs are registered or decoded from state.

## Structure
- Shared package / defines file:
  - the `` `N `` width define, shared with the adder;
  - state encodings IDLE=2'd0, ACC=2'd1, DONE=2'd2.
- Sub-module: one instance of `generate_fa` as the datapath adder.
  - Inputs: a_in=acc, b_in=`data_in`, c_in=0.
  - Outputs: sum_out and carry_out feed the acc and ovf register inputs.
- Everything else (FSM, down-counter, output registers) lives in `add_accumulator`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACC after 2 of 4 samples → all outputs 0 immediately. After release, state is IDLE, and a new start with len 2 and samples 3, 4 → `sum_out`=7.
- **Basic frame:** len 3, samples 10, 20, 30 with valid held high → `result_valid_out` one cycle after the third sample, `sum_out`=60, `carry_out`=0.
- **Overflow:** N=8, len 2, samples 200, 100 → `sum_out`=44, `carry_out`=1.
- **Sticky flag:** len 3, samples 255, 1, 5 → `sum_out`=5, `carry_out`=1 (flag stays set after the wrap).
- **Valid gaps and empty frame:** len 2 with `data_valid_in` toggling 1,0,0,1 → only 2 transfers, result correct. Then len 0 → result 0/0 one cycle after start.
- **Result back-pressure:** hold `result_ready_in`=0 for 5 cycles → outputs stable, `start_in` ignored, `data_ready_out`=0. Raise `result_ready_in` → IDLE next cycle.
